sar_result_buffer: RTL and testbench
====================================

Name: sar_result_buffer

Overview:
- Downstream consumer of the SAR conversion logic; sits between the SAR end-of-conversion output and the Wishbone bus inside user_project_wrapper.
- Captures each finished conversion word and box-car averages 2^AVG_LOG2 words.
- Averaged results are pushed into a FIFO that the management core drains over Wishbone.
- Raises user_irq when the FIFO fill level reaches a programmable threshold.

Parameters:
- DATA_W, 10, conversion result width in bits.
- AVG_LOG2, 2, log2 of samples per average; 0 means pass-through.
- DEPTH, 16, FIFO entries; power of 2, range 2..128.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- sample_in  in  DATA_W  conversion result from SAR logic.
- sample_valid  in  1  one-cycle strobe; sample_in valid this cycle.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_adr_i  in  32  Wishbone address; only [3:2] decoded.
- wbs_dat_i  in  32  Wishbone write data.
- wbs_sel_i  in  4  byte selects; ignored, all writes are full-word.
- wbs_ack_o  out  1  Wishbone acknowledge.
- wbs_dat_o  out  32  Wishbone read data.
- irq  out  1  threshold interrupt, level.

Behaviour:
- Reset: wbs_ack_o=0, wbs_dat_o=0, irq=0, FIFO empty, count=0, overflow=0, enable=0, thresh=0, accumulator=0, sample counter=0.
- Register map (adr[3:2]):
  - 0 DATA: read pops. Bits [DATA_W-1:0]=result, rest 0. Reading an empty FIFO returns 0 and does not pop. Writes ignored.
  - 1 STATUS: bit0 empty, bit1 full, bit2 overflow (sticky), bits[15:8] count. Writing 1 to bit2 clears overflow; other bits read-only.
  - 2 CTRL: bit0 enable (R/W). bit1 flush: write-1, self-clearing, reads 0.
  - 3 THRESH: bits[7:0] R/W.
- Wishbone handshake:
  - Access starts when cyc&stb&!ack; ack is a 1-cycle pulse in the next cycle.
  - wbs_dat_o is registered and valid in the ack cycle; it returns to 0 otherwise.
  - Register write and FIFO pop take effect on the ack edge.
  - Back-to-back accesses: ack at most every second cycle.
- Averaging:
  - Accumulator width is DATA_W+AVG_LOG2; sample counter is AVG_LOG2 bits wide.
  - On sample_valid&enable: acc+=sample_in, cnt++.
  - On the 2^AVG_LOG2-th sample: push (acc+sample_in)>>AVG_LOG2 (truncate), then set acc=0, cnt=0 in the same cycle.
  - AVG_LOG2=0: every valid sample is pushed unchanged.
  - Latency: FIFO count updates the cycle after the completing sample_valid.
- enable=0: sample_valid ignored; acc and cnt are held at 0; FIFO contents retained and still readable.
- Clearing enable mid-average discards the partial sum.
- FIFO boundary cases:
  - Push while full and no pop that cycle: sample dropped, overflow set to 1.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: read returns 0 (no bypass), push lands, count=1.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Flush: empties FIFO, clears acc and cnt, leaves overflow and enable unchanged. A push in the flush cycle is discarded.
- Simultaneous STATUS write-1 to bit2 and a new overflow in the same cycle: overflow ends at 1 (set wins).
- irq: registered, irq = enable && thresh!=0 && count>=thresh. Deasserts one cycle after count drops below thresh.
- Reset mid-operation (any cycle, including an in-flight ack): everything returns to reset values at the next edge; no ack is issued for the aborted access.

Optional Feature:
- Macro: SAR_BUF_TIMESTAMP_EN.
- Defined:
  - A 16-bit free-running counter increments every clock and resets to 0; it wraps 0xFFFF->0.
  - The counter value in the cycle of each push is stored with the entry.
  - DATA read returns that timestamp in bits [31:16].
  - FIFO entry width becomes DATA_W+16.
- Undefined: no counter and no extra storage; DATA bits [31:16] read 0.

Test Plan:
- Reset, then read STATUS -> 0x00000001 (empty); read CTRL -> 0; irq=0; every ack is exactly 1 cycle.
- AVG_LOG2=2, enable=1, feed samples 10,20,30,41 -> count=1; DATA read=0x19 (101>>2=25); STATUS returns to empty.
- AVG_LOG2=0, DEPTH=16: push 17 samples without reading -> full=1, overflow=1, count=16; write STATUS 0x4 -> overflow=0, full stays 1.
- thresh=3: push 3 results -> irq rises the cycle after the third push; one DATA read -> irq falls the cycle after the pop.
- FIFO full plus a DATA read ack coinciding with a completing sample -> count stays 16, overflow stays 0, read returns the oldest entry; also read DATA while empty -> returns 0, count stays 0.
- Mid-average (2 of 4 samples), write CTRL=0x3 -> FIFO empty, next 4 samples 4,4,4,4 yield result 4; with SAR_BUF_TIMESTAMP_EN, a push at timer value 0x1234 reads back 0x12340004.

Source files
------------

// File: rtl/sar_result_buffer.sv
// sar_result_buffer: box-car averages SAR results into a Wishbone-drained FIFO with threshold irq; optional SAR_BUF_TIMESTAMP_EN stores a 16-bit timestamp per entry.
module sar_result_buffer #(
    parameter int DATA_W   = 10,
    parameter int AVG_LOG2 = 2,
    parameter int DEPTH    = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [3:0]        wbs_sel_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              irq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
`ifdef SAR_BUF_TIMESTAMP_EN
    localparam int EW = DATA_W + 16;
`else
    localparam int EW = DATA_W;
`endif

    logic              ack_q, irq_q, irq_d, en_q, en_d, ovf_q, ovf_d;
    logic [31:0]       dat_q, dat_d;
    logic [7:0]        thr_q, thr_d, fill8;
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     fill_q, fill_d;
    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     entry;
    logic [31:0]       data_word;
    logic [1:0]        sel;
    logic              start, acc_rd, acc_wr, empty, full, pop, flush, push, push_ok, ovf_clr;
    logic [DATA_W-1:0] push_data;
    logic              unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:8]};
    assign sel       = wbs_adr_i[3:2];
    assign start     = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign acc_rd    = start & ~wbs_we_i;
    assign acc_wr    = start & wbs_we_i;
    assign empty     = fill_q == '0;
    assign full      = fill_q == CW'(DEPTH);
    assign fill8     = 8'(fill_q);
    assign pop       = acc_rd && sel == 2'd0 && !empty;
    assign flush     = acc_wr && sel == 2'd2 && wbs_dat_i[1];
    assign ovf_clr   = acc_wr && sel == 2'd1 && wbs_dat_i[2];
    assign push_ok   = push && !flush && (!full || pop);

    generate
        if (AVG_LOG2 == 0) begin : g_pass
            assign push      = sample_valid & en_q;
            assign push_data = sample_in;
        end else begin : g_avg
            localparam int AW = DATA_W + AVG_LOG2;
            logic [AW-1:0]       acc_q, acc_d, sum;
            logic [AVG_LOG2-1:0] scnt_q, scnt_d;
            logic                take, last;
            // Accumulate enabled samples; the last of each group completes an average
            always_comb begin
                take      = sample_valid & en_q;
                last      = scnt_q == '1;
                sum       = acc_q + AW'(sample_in);
                push      = take & last;
                push_data = DATA_W'(sum >> AVG_LOG2);
                acc_d     = (!en_q || flush || (take && last)) ? '0 : take ? sum : acc_q;
                scnt_d    = (!en_q || flush) ? '0 : take ? scnt_q + AVG_LOG2'(1) : scnt_q;
            end
            // Averager state register
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    acc_q  <= '0;
                    scnt_q <= '0;
                end else begin
                    acc_q  <= acc_d;
                    scnt_q <= scnt_d;
                end
            end
        end
    endgenerate

`ifdef SAR_BUF_TIMESTAMP_EN
    logic [15:0] ts_q;
    // Free-running timestamp tagged onto each pushed entry
    always_ff @(posedge wb_clk_i) begin
        ts_q <= wb_rst_i ? 16'd0 : ts_q + 16'd1;
    end
    assign entry     = {ts_q, push_data};
    assign data_word = empty ? 32'd0 : {mem[rptr_q][EW-1:DATA_W], 16'(mem[rptr_q][DATA_W-1:0])};
`else
    assign entry     = push_data;
    assign data_word = empty ? 32'd0 : 32'(mem[rptr_q]);
`endif

    // Next-state for FIFO pointers, control registers, read data and irq
    always_comb begin
        wptr_d = flush ? '0 : push_ok ? wptr_q + PW'(1) : wptr_q;
        rptr_d = flush ? '0 : pop ? rptr_q + PW'(1) : rptr_q;
        fill_d = flush ? '0 : fill_q + CW'(push_ok) - CW'(pop);
        ovf_d  = (push && !flush && full && !pop) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
        en_d   = (acc_wr && sel == 2'd2) ? wbs_dat_i[0] : en_q;
        thr_d  = (acc_wr && sel == 2'd3) ? wbs_dat_i[7:0] : thr_q;
        irq_d  = en_q && thr_q != 8'd0 && fill8 >= thr_q;
        dat_d  = !acc_rd ? 32'd0 :
                 sel == 2'd0 ? data_word :
                 sel == 2'd1 ? {16'd0, fill8, 5'd0, ovf_q, full, empty} :
                 sel == 2'd2 ? {31'd0, en_q} : {24'd0, thr_q};
    end

    // Control and status registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            irq_q  <= 1'b0;
            en_q   <= 1'b0;
            ovf_q  <= 1'b0;
            thr_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            ack_q  <= start;
            dat_q  <= dat_d;
            irq_q  <= irq_d;
            en_q   <= en_d;
            ovf_q  <= ovf_d;
            thr_q  <= thr_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fill_q <= fill_d;
        end
    end

    // FIFO storage, written only on an accepted push
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem[wptr_q] <= entry;
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;
endmodule

// File: tb/tb_sar_result_buffer.sv
// tb_sar_result_buffer: directed bench for an averaging (AVG_LOG2=2) and a pass-through (AVG_LOG2=0) instance.
module tb_sar_result_buffer;
`ifdef SAR_BUF_TIMESTAMP_EN
    localparam logic [31:0] DMASK = 32'h0000FFFF;
`else
    localparam logic [31:0] DMASK = 32'hFFFFFFFF;
`endif
    localparam logic [1:0] R_DATA = 2'd0, R_STAT = 2'd1, R_CTRL = 2'd2, R_THR = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  sin = '0;
    logic        sv_a = 1'b0, sv_b = 1'b0, cyc_a = 1'b0, cyc_b = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dati = '0;
    logic [3:0]  sel = 4'hF;
    logic        ack_a, ack_b, irq_a, irq_b;
    logic [31:0] dat_a, dat_b;
    logic [15:0] tb_ts = '0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tb_ts <= rst ? 16'd0 : tb_ts + 16'd1;

    sar_result_buffer #(.DATA_W(10), .AVG_LOG2(2), .DEPTH(16)) u_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .sample_in(sin), .sample_valid(sv_a),
        .wbs_cyc_i(cyc_a), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_adr_i(adr),
        .wbs_dat_i(dati), .wbs_sel_i(sel), .wbs_ack_o(ack_a), .wbs_dat_o(dat_a), .irq(irq_a)
    );

    sar_result_buffer #(.DATA_W(10), .AVG_LOG2(0), .DEPTH(16)) u_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .sample_in(sin), .sample_valid(sv_b),
        .wbs_cyc_i(cyc_b), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_adr_i(adr),
        .wbs_dat_i(dati), .wbs_sel_i(sel), .wbs_ack_o(ack_b), .wbs_dat_o(dat_b), .irq(irq_b)
    );

    task automatic wb(input bit b, input bit w, input logic [1:0] a, input logic [31:0] d,
                      input bit sv, input logic [9:0] sval, output logic [31:0] q, output bit ok);
        if (b) cyc_b = 1'b1; else cyc_a = 1'b1;
        stb = 1'b1; we = w; adr = {28'd0, a, 2'b00}; dati = d;
        if (sv) begin
            sin = sval;
            if (b) sv_b = 1'b1; else sv_a = 1'b1;
        end
        @(posedge clk); #1;
        sv_a = 1'b0; sv_b = 1'b0;
        ok = (b ? ack_b : ack_a) === 1'b1;
        q = b ? dat_b : dat_a;
        cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        ok = ok && ((b ? ack_b : ack_a) === 1'b0);
    endtask

    task automatic smp(input bit b, input logic [9:0] v);
        sin = v;
        if (b) sv_b = 1'b1; else sv_a = 1'b1;
        @(posedge clk); #1;
        sv_a = 1'b0; sv_b = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] q;
        bit ok;
        cyc_a = 1'b1; stb = 1'b1; adr = 32'h4;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ack_a !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack_a); end
        cyc_a = 1'b0; stb = 1'b0; rst = 1'b0;
        checks++;
        if (dat_a !== 32'd0 || irq_a !== 1'b0) begin
            failures++; $display("FAIL reset_outs dat=%h irq=%b exp=0/0", dat_a, irq_a);
        end
        wb(0, 0, R_STAT, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h1 || !ok) begin failures++; $display("FAIL reset_status got=%h ack_ok=%b exp=00000001", q, ok); end
        wb(0, 0, R_CTRL, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h0 || !ok) begin failures++; $display("FAIL reset_ctrl got=%h ack_ok=%b exp=0", q, ok); end
        wb(1, 0, R_STAT, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h1 || !ok) begin failures++; $display("FAIL reset_status_b got=%h exp=00000001", q); end
        checks++;
        if (dat_a !== 32'd0) begin failures++; $display("FAIL dat_idle got=%h exp=0", dat_a); end
    endtask

    task automatic test_average;
        logic [31:0] q;
        bit ok;
        wb(0, 1, R_CTRL, 1, 0, 0, q, ok);
        smp(0, 10); smp(0, 20); smp(0, 30); smp(0, 41);
        wb(0, 0, R_STAT, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h100) begin failures++; $display("FAIL avg_count got=%h exp=00000100", q); end
        wb(0, 0, R_DATA, 0, 0, 0, q, ok);
        checks++;
        if ((q & DMASK) !== 32'h19) begin failures++; $display("FAIL avg_data got=%h exp=00000019", q); end
        wb(0, 0, R_STAT, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h1) begin failures++; $display("FAIL avg_empty got=%h exp=00000001", q); end
    endtask

    task automatic test_irq;
        logic [31:0] q;
        bit ok;
        wb(0, 1, R_THR, 3, 0, 0, q, ok);
        for (int i = 0; i < 11; i++) smp(0, 8);
        checks++;
        if (irq_a !== 1'b0) begin failures++; $display("FAIL irq_below got=%b exp=0", irq_a); end
        smp(0, 8);
        checks++;
        if (irq_a !== 1'b0) begin failures++; $display("FAIL irq_lag got=%b exp=0", irq_a); end
        @(posedge clk); #1;
        checks++;
        if (irq_a !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq_a); end
        wb(0, 0, R_DATA, 0, 0, 0, q, ok);
        checks++;
        if ((q & DMASK) !== 32'h8) begin failures++; $display("FAIL irq_data got=%h exp=00000008", q); end
        checks++;
        if (irq_a !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", irq_a); end
        wb(0, 0, R_STAT, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h200) begin failures++; $display("FAIL irq_count got=%h exp=00000200", q); end
        wb(0, 0, R_THR, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h3) begin failures++; $display("FAIL thresh_rd got=%h exp=00000003", q); end
        wb(0, 0, R_DATA, 0, 0, 0, q, ok);
        wb(0, 0, R_DATA, 0, 0, 0, q, ok);
        wb(0, 1, R_THR, 0, 0, 0, q, ok);
    endtask

    task automatic test_flush;
        logic [31:0] q;
        bit ok;
        for (int i = 0; i < 4; i++) smp(0, 40);
        smp(0, 100); smp(0, 100);
        wb(0, 1, R_CTRL, 3, 0, 0, q, ok);
        wb(0, 0, R_STAT, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h1) begin failures++; $display("FAIL flush_status got=%h exp=00000001", q); end
        wb(0, 0, R_CTRL, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h1) begin failures++; $display("FAIL flush_ctrl got=%h exp=00000001", q); end
        for (int i = 0; i < 4; i++) smp(0, 4);
        wb(0, 0, R_DATA, 0, 0, 0, q, ok);
        checks++;
        if ((q & DMASK) !== 32'h4) begin failures++; $display("FAIL flush_avg got=%h exp=00000004", q); end
    endtask

    task automatic test_disable;
        logic [31:0] q;
        bit ok;
        for (int i = 0; i < 4; i++) smp(0, 12);
        wb(0, 1, R_CTRL, 0, 0, 0, q, ok);
        for (int i = 0; i < 4; i++) smp(0, 9);
        wb(0, 0, R_STAT, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h100) begin failures++; $display("FAIL dis_status got=%h exp=00000100", q); end
        wb(0, 0, R_DATA, 0, 0, 0, q, ok);
        checks++;
        if ((q & DMASK) !== 32'hC) begin failures++; $display("FAIL dis_retained got=%h exp=0000000c", q); end
        wb(0, 1, R_CTRL, 1, 0, 0, q, ok);
        smp(0, 100); smp(0, 100);
        wb(0, 1, R_CTRL, 0, 0, 0, q, ok);
        wb(0, 1, R_CTRL, 1, 0, 0, q, ok);
        for (int i = 0; i < 4; i++) smp(0, 12);
        wb(0, 0, R_DATA, 0, 0, 0, q, ok);
        checks++;
        if ((q & DMASK) !== 32'hC) begin failures++; $display("FAIL dis_discard got=%h exp=0000000c", q); end
    endtask

    task automatic test_overflow;
        logic [31:0] q;
        bit ok;
        wb(1, 1, R_CTRL, 1, 0, 0, q, ok);
        for (int i = 1; i <= 17; i++) smp(1, 10'(i));
        wb(1, 0, R_STAT, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h1006) begin failures++; $display("FAIL ovf_status got=%h exp=00001006", q); end
        wb(1, 1, R_STAT, 4, 1, 60, q, ok);
        wb(1, 0, R_STAT, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h1006) begin failures++; $display("FAIL ovf_set_wins got=%h exp=00001006", q); end
        wb(1, 1, R_STAT, 4, 0, 0, q, ok);
        wb(1, 0, R_STAT, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h1002) begin failures++; $display("FAIL ovf_clear got=%h exp=00001002", q); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] q;
        bit ok;
        wb(1, 0, R_DATA, 0, 1, 99, q, ok);
        checks++;
        if ((q & DMASK) !== 32'h1) begin failures++; $display("FAIL full_pushpop_data got=%h exp=00000001", q); end
        wb(1, 0, R_STAT, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h1002) begin failures++; $display("FAIL full_pushpop_status got=%h exp=00001002", q); end
        for (int i = 0; i < 16; i++) begin
            wb(1, 0, R_DATA, 0, 0, 0, q, ok);
            checks++;
            if ((q & DMASK) !== ((i < 15) ? 32'(i + 2) : 32'd99)) begin
                failures++; $display("FAIL drain_%0d got=%h exp=%h", i, q, (i < 15) ? 32'(i + 2) : 32'd99);
            end
        end
        wb(1, 0, R_DATA, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h0) begin failures++; $display("FAIL empty_read got=%h exp=0", q); end
        wb(1, 0, R_STAT, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h1) begin failures++; $display("FAIL empty_status got=%h exp=00000001", q); end
        wb(1, 0, R_DATA, 0, 1, 7, q, ok);
        checks++;
        if (q !== 32'h0) begin failures++; $display("FAIL empty_pushpop_data got=%h exp=0", q); end
        wb(1, 0, R_STAT, 0, 0, 0, q, ok);
        checks++;
        if (q !== 32'h100) begin failures++; $display("FAIL empty_pushpop_status got=%h exp=00000100", q); end
        wb(1, 0, R_DATA, 0, 0, 0, q, ok);
        checks++;
        if ((q & DMASK) !== 32'h7) begin failures++; $display("FAIL empty_pushpop_land got=%h exp=00000007", q); end
    endtask

`ifdef SAR_BUF_TIMESTAMP_EN
    task automatic test_timestamp;
        logic [31:0] q;
        bit ok;
        int guard = 0;
        while (tb_ts != 16'h1234 && guard < 70000) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (tb_ts != 16'h1234) begin
            failures++; $display("FAIL ts_wait got=%h exp=1234", tb_ts);
        end else begin
            smp(1, 4);
            wb(1, 0, R_DATA, 0, 0, 0, q, ok);
            checks++;
            if (q !== 32'h12340004) begin failures++; $display("FAIL ts_data got=%h exp=12340004", q); end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_average;
        test_irq;
        test_flush;
        test_disable;
        test_overflow;
        test_back_to_back;
`ifdef SAR_BUF_TIMESTAMP_EN
        test_timestamp;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
